// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags,
// sticky overflow/underflow errors and optional first-word-fall-through reads.
module sync_fifo_ext #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned PW       = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    input  logic             clr_err,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status decodes from the count register only, so no request reaches an output.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky errors: a new rejection wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_ok) begin
                    rd_q <= mem[rd_ptr];
                end
            end
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: a DEPTH=5 registered-read FIFO, the default
// DEPTH=16 FIFO for thresholds, and a DEPTH=4 FWFT FIFO.
module tb_sync_fifo_ext;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_comp = 0;
    int n_fail = 0;

    // Instance A: DEPTH=5, registered read
    logic       a_wr, a_rd, a_clr;
    logic [7:0] a_wd, a_rdata;
    logic [2:0] a_cnt;
    logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;

    // Instance B: defaults (DEPTH=16, AF=14, AE=2)
    logic       b_wr, b_rd, b_clr;
    logic [7:0] b_wd, b_rdata;
    logic [4:0] b_cnt;
    logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;

    // Instance C: DEPTH=4, first-word-fall-through
    logic       c_wr, c_rd, c_clr;
    logic [7:0] c_wd, c_rdata;
    logic [2:0] c_cnt;
    logic       c_full, c_empty, c_af, c_ae, c_ov, c_un;

    sync_fifo_ext #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(a_wr), .wr_data(a_wd), .rd_en(a_rd), .rd_data(a_rdata),
        .clr_err(a_clr), .count(a_cnt), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ov), .underflow(a_un)
    );

    sync_fifo_ext u_b (
        .clk(clk), .rst(rst), .wr_en(b_wr), .wr_data(b_wd), .rd_en(b_rd), .rd_data(b_rdata),
        .clr_err(b_clr), .count(b_cnt), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ov), .underflow(b_un)
    );

    sync_fifo_ext #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_c (
        .clk(clk), .rst(rst), .wr_en(c_wr), .wr_data(c_wd), .rd_en(c_rd), .rd_data(c_rdata),
        .clr_err(c_clr), .count(c_cnt), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .overflow(c_ov), .underflow(c_un)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_comp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {a_wr, a_rd, a_clr, b_wr, b_rd, b_clr, c_wr, c_rd, c_clr} = '0;
        a_wd = '0; b_wd = '0; c_wd = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_a_empty", 32'(a_empty), 1);
        chk("rst_a_full", 32'(a_full), 0);
        chk("rst_a_ae", 32'(a_ae), 1);
        chk("rst_a_af", 32'(a_af), 0);
        chk("rst_a_ov", 32'(a_ov), 0);
        chk("rst_a_un", 32'(a_un), 0);
        chk("rst_a_rdata", 32'(a_rdata), 0);
        chk("rst_b_full", 32'(b_full), 0);
        chk("rst_c_rdata", 32'(c_rdata), 0);
        chk("rst_c_empty", 32'(c_empty), 1);

        // Fill DEPTH=5, then one rejected write
        for (int i = 0; i < 5; i++) begin
            a_wr = 1'b1; a_wd = 8'(8'h11 + i);
            tick();
            chk("fill_cnt", 32'(a_cnt), 32'(i + 1));
        end
        chk("fill_full", 32'(a_full), 1);
        chk("fill_af", 32'(a_af), 1);
        chk("fill_ov_pre", 32'(a_ov), 0);
        a_wd = 8'h16;
        tick();
        a_wr = 1'b0;
        chk("rej_ov", 32'(a_ov), 1);
        chk("rej_cnt", 32'(a_cnt), 5);

        // Drain in order
        for (int i = 0; i < 5; i++) begin
            a_rd = 1'b1;
            tick();
            chk("drain_data", 32'(a_rdata), 32'(8'h11 + i));
        end
        a_rd = 1'b0;
        chk("drain_empty", 32'(a_empty), 1);
        chk("drain_cnt", 32'(a_cnt), 0);

        // Overflow holds through idle cycles
        repeat (10) tick();
        chk("ov_hold", 32'(a_ov), 1);

        // Simultaneous at empty: write accepted, read rejected
        a_wr = 1'b1; a_wd = 8'h21; a_rd = 1'b1;
        tick();
        a_wr = 1'b0; a_rd = 1'b0;
        chk("se_cnt", 32'(a_cnt), 1);
        chk("se_un", 32'(a_un), 1);
        chk("se_rdata_hold", 32'(a_rdata), 8'h15);

        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1; a_wd = 8'(8'h22 + i);
            tick();
        end
        a_wr = 1'b0;
        chk("refill_cnt", 32'(a_cnt), 5);

        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("clr_ov", 32'(a_ov), 0);
        chk("clr_un", 32'(a_un), 0);

        // Simultaneous at full: read accepted, write rejected
        a_wr = 1'b1; a_wd = 8'h26; a_rd = 1'b1;
        tick();
        a_wr = 1'b0; a_rd = 1'b0;
        chk("sf_cnt", 32'(a_cnt), 4);
        chk("sf_ov", 32'(a_ov), 1);
        chk("sf_rdata", 32'(a_rdata), 8'h21);

        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        a_wr = 1'b1; a_wd = 8'h27;
        tick();
        chk("full2_ov_clr", 32'(a_ov), 0);
        chk("full2", 32'(a_full), 1);
        // Set beats clear
        a_wd = 8'h28; a_clr = 1'b1;
        tick();
        a_wr = 1'b0;
        chk("set_over_clr", 32'(a_ov), 1);
        tick();
        a_clr = 1'b0;
        chk("clr_alone", 32'(a_ov), 0);

        // Contents now 22,23,24,25,27; read two to reach count 3
        a_rd = 1'b1;
        tick();
        chk("r22", 32'(a_rdata), 8'h22);
        tick();
        chk("r23", 32'(a_rdata), 8'h23);
        a_wr = 1'b1; a_wd = 8'h29;
        tick();
        a_wr = 1'b0;
        chk("s3_cnt", 32'(a_cnt), 3);
        chk("s3_data", 32'(a_rdata), 8'h24);
        tick();
        chk("r25", 32'(a_rdata), 8'h25);
        tick();
        chk("r27", 32'(a_rdata), 8'h27);
        tick();
        a_rd = 1'b0;
        chk("r29", 32'(a_rdata), 8'h29);
        chk("s3_empty", 32'(a_empty), 1);

        // Wrap: 12 interleaved write/read pairs plus a standing word
        a_wr = 1'b1; a_wd = 8'h3F;
        tick();
        a_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            a_wr = 1'b1; a_wd = 8'(8'h40 + i);
            tick();
            a_wr = 1'b0;
            chk("wrap_wptr", 32'(u_a.wr_ptr <= 3'd4), 1);
            a_rd = 1'b1;
            tick();
            a_rd = 1'b0;
            chk("wrap_data", 32'(a_rdata), (i == 0) ? 32'h3F : 32'(8'h40 + i - 1));
            chk("wrap_rptr", 32'(u_a.rd_ptr <= 3'd4), 1);
        end
        chk("wrap_cnt", 32'(a_cnt), 1);

        // Reset mid-fill with pending errors
        a_rd = 1'b1;
        tick();
        chk("pre_rst_last", 32'(a_rdata), 8'h4B);
        tick();
        a_rd = 1'b0;
        chk("pre_rst_un", 32'(a_un), 1);
        for (int i = 0; i < 3; i++) begin
            a_wr = 1'b1; a_wd = 8'(8'h50 + i);
            tick();
        end
        rst = 1'b1; a_clr = 1'b0;
        tick();
        rst = 1'b0; a_wr = 1'b0;
        chk("mrst_cnt", 32'(a_cnt), 0);
        chk("mrst_empty", 32'(a_empty), 1);
        chk("mrst_un", 32'(a_un), 0);
        chk("mrst_rdata", 32'(a_rdata), 0);

        // Thresholds on DEPTH=16
        for (int k = 1; k <= 16; k++) begin
            b_wr = 1'b1; b_wd = 8'(k);
            tick();
            chk("thr_cnt", 32'(b_cnt), 32'(k));
            chk("thr_ae", 32'(b_ae), 32'(k <= 2));
            chk("thr_af", 32'(b_af), 32'(k >= 14));
            chk("thr_full", 32'(b_full), 32'(k == 16));
        end
        b_wr = 1'b0;

        // FWFT
        c_wr = 1'b1; c_wd = 8'hA5;
        tick();
        c_wr = 1'b0;
        chk("fw_data", 32'(c_rdata), 8'hA5);
        chk("fw_nempty", 32'(c_empty), 0);
        c_rd = 1'b1;
        tick();
        c_rd = 1'b0;
        chk("fw_pop_empty", 32'(c_empty), 1);
        chk("fw_pop_data", 32'(c_rdata), 0);
        c_wr = 1'b1; c_wd = 8'hB1;
        tick();
        c_wd = 8'hC2;
        tick();
        c_wr = 1'b0;
        chk("fw_head1", 32'(c_rdata), 8'hB1);
        c_rd = 1'b1;
        tick();
        chk("fw_head2", 32'(c_rdata), 8'hC2);
        tick();
        c_rd = 1'b0;
        chk("fw_end", 32'(c_rdata), 0);
        chk("fw_un", 32'(c_un), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised synchronous FIFO, successor to the single-clock 4-deep byte FIFO. Adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Adds a selectable first-word-fall-through (FWFT) read mode. Sits between single-clock producers and consumers, such as the UART/SPI byte paths and the bus bridge.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of storage words (>=2, any integer)
- FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
- Derived: PW = clog2(DEPTH) pointer width (min 1); CW = clog2(DEPTH+1) count width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read (pop) request
- rd_data  out  WIDTH  read data (see Operation)
- clr_err  in  1  clears the sticky overflow/underflow flags
- count  out  CW  current occupancy, 0..DEPTH
- full / empty  out  1  count==DEPTH / count==0
- almost_full / almost_empty  out  1  threshold flags as defined above
- overflow / underflow  out  1  sticky error flags

## Operation
- Write accepted iff wr_en && !full; the word is stored at wr_ptr, and wr_ptr advances.
- Read accepted iff rd_en && !empty; rd_ptr advances.
- Acceptance is decided on the pre-edge state:
  - a write while full is rejected, even if a read is accepted in the same cycle;
  - a read while empty is rejected, even if a write is accepted in the same cycle.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0, never DEPTH..2^PW-1. This is required for non-power-of-two DEPTH.
- count:
  - +1 on write-only acceptance;
  - -1 on read-only acceptance;
  - unchanged when both or neither are accepted.
- All status flags decode combinationally from the count register. Flags and count therefore change together on the accepting edge.
- FWFT=0: on an accepted read, rd_data <= mem[rd_ptr] at that edge. rd_data holds otherwise, including on rejected reads.
- FWFT=1: rd_data = mem[rd_ptr] combinationally while !empty, and 0 while empty. rd_en acknowledges (pops) the displayed word.
- Rejected write sets overflow at that edge. Rejected read sets underflow at that edge.
- clr_err clears both sticky flags; set has priority over clr_err in the same cycle.
- Memory contents are not cleared by reset.

## Timing
- Reset (rst high at an edge) sets:
  - wr_ptr = rd_ptr = 0, count = 0;
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0 (AF_THRESH >= 1);
  - overflow = underflow = 0;
  - rd_data = 0.
- rst overrides all simultaneous wr_en, rd_en and clr_err. Reset mid-operation discards all content immediately.
- Write to status: accepted write at edge N gives count/empty updated after N. In FWFT mode the word is visible on rd_data after edge N.
- Read latency:
  - FWFT=0: data valid after the accepting edge (1 cycle);
  - FWFT=1: data is valid before the pop, 0 cycles.
- Throughput: 1 write and 1 read per cycle sustained when 0 < count < DEPTH.
- No combinational path from wr_en/rd_en to any output.

## Test plan
- Reset, then write 0x11..0x15 into a DEPTH=5 FIFO, then write 0x16:
  - count = 5, full = 1 after the fifth write;
  - 0x16 is rejected, overflow = 1 next cycle;
  - drain reads 0x11..0x15 in order.
- DEPTH=5 wrap: push/pop 12 words with interleaved single reads and writes. Data order is preserved, and pointers never exceed 4.
- Simultaneous read and write:
  - at count = 3: count stays 3, data order intact;
  - at full: read accepted, write rejected, count = 4, overflow = 1;
  - at empty: write accepted, read rejected, count = 1, underflow = 1.
- Thresholds (DEPTH=16, AF=14, AE=2):
  - almost_empty deasserts on the edge count goes 2 -> 3;
  - almost_full asserts on 13 -> 14;
  - full asserts at 16.
- FWFT=1: write 0xA5 into an empty FIFO. rd_data = 0xA5 and empty = 0 the cycle after. rd_en pops it, giving empty = 1 and rd_data = 0.
- Sticky flags: overflow held through 10 idle cycles. clr_err together with a new rejected write leaves overflow = 1. clr_err alone clears it. rst mid-fill clears count, flags and errors at the next edge.
